// File: rtl/usb_bus_state_if.sv
// Bus-state tracker signal bundle: phy/packet-side inputs plus status, event and wake-pad outputs.
// The slave modport is the tracker's view; the master modport is the driver/observer view.
interface usb_bus_state_if;
    logic       pu_ena;
    logic       rx_dp;
    logic       rx_dn;
    logic       sof_stb;
    logic       clr_rst_pending;
    logic       wakeup_req;
    logic [2:0] state;
    logic       usb_reset;
    logic       usb_suspend;
    logic       rst_pending;
    logic       evt_reset;
    logic       evt_suspend;
    logic       evt_resume;
    logic       wake_tx_en;
    logic       wake_tx_k;

    modport master (
        output pu_ena, rx_dp, rx_dn, sof_stb, clr_rst_pending, wakeup_req,
        input  state, usb_reset, usb_suspend, rst_pending,
        input  evt_reset, evt_suspend, evt_resume, wake_tx_en, wake_tx_k
    );

    modport slave (
        input  pu_ena, rx_dp, rx_dn, sof_stb, clr_rst_pending, wakeup_req,
        output state, usb_reset, usb_suspend, rst_pending,
        output evt_reset, evt_suspend, evt_resume, wake_tx_en, wake_tx_k
    );
endinterface

// File: rtl/usb_bus_state.sv
// USB full-speed bus-state tracker: attach, bus reset, suspend, host resume and
// optional device remote wakeup. Timers scale with CLK_MHZ.
// Optional feature: define USB_BUS_STATE_WAKEUP_EN to enable remote wakeup (WAKEUP state).
module usb_bus_state #(
    parameter int unsigned CLK_MHZ       = 48,
    parameter int unsigned RESET_US      = 10000,
    parameter int unsigned SUSPEND_US    = 3000,
    parameter int unsigned RESUME_DEB_US = 20,
    parameter int unsigned WAKE_MIN_US   = 2000,
    parameter int unsigned WAKE_K_US     = 2000
) (
    input  logic             clk,
    input  logic             rst_n,
    usb_bus_state_if.slave   bus
);

    localparam int unsigned RESET_CYC   = CLK_MHZ * RESET_US;
    localparam int unsigned SUSPEND_CYC = CLK_MHZ * SUSPEND_US;
    localparam int unsigned RESUME_CYC  = CLK_MHZ * RESUME_DEB_US;
    localparam int unsigned SE0_W       = $clog2(RESET_CYC + 1);
    localparam int unsigned IDLE_W      = $clog2(SUSPEND_CYC + 1);
    localparam int unsigned K_W         = $clog2(RESUME_CYC + 1);

    typedef enum logic [2:0] {
        ST_DETACHED = 3'd0,
        ST_ACTIVE   = 3'd1,
        ST_RESET    = 3'd2,
        ST_SUSPEND  = 3'd3,
        ST_RESUME   = 3'd4,
        ST_WAKEUP   = 3'd5
    } state_t;

    state_t              state_q;
    state_t              state_nxt;
    logic [SE0_W-1:0]    se0_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [K_W-1:0]      k_cnt;
    logic                line_j;
    logic                line_k;
    logic                line_se0;
    logic                se0_hit;
    logic                idle_hit;
    logic                k_hit;

    // Line decode; SE1 decodes as none of J/K/SE0
    assign line_j   =  bus.rx_dp & ~bus.rx_dn;
    assign line_k   = ~bus.rx_dp &  bus.rx_dn;
    assign line_se0 = ~bus.rx_dp & ~bus.rx_dn;

    // Timer thresholds are checked on the sample that completes the interval
    assign se0_hit  = line_se0 && (se0_cnt == SE0_W'(RESET_CYC - 1));
    assign idle_hit = line_j && !bus.sof_stb && (idle_cnt == IDLE_W'(SUSPEND_CYC - 1));
    assign k_hit    = line_k && (k_cnt == K_W'(RESUME_CYC - 1));

`ifdef USB_BUS_STATE_WAKEUP_EN
    localparam int unsigned WMIN_CYC = CLK_MHZ * WAKE_MIN_US;
    localparam int unsigned WK_CYC   = CLK_MHZ * WAKE_K_US;
    localparam int unsigned WMIN_W   = $clog2(WMIN_CYC + 1);
    localparam int unsigned WK_W     = $clog2(WK_CYC + 1);

    logic [WMIN_W-1:0]   susp_cnt;
    logic [WK_W-1:0]     wk_cnt;
    logic                wake_go;
    logic                wk_done;

    assign wake_go = bus.wakeup_req && (susp_cnt == WMIN_W'(WMIN_CYC));
    assign wk_done = (wk_cnt == WK_W'(WK_CYC - 1));

    // Suspend dwell and K-drive timers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            susp_cnt <= '0;
            wk_cnt   <= '0;
        end else begin
            if (state_q != ST_SUSPEND)
                susp_cnt <= '0;
            else if (susp_cnt != WMIN_W'(WMIN_CYC))
                susp_cnt <= susp_cnt + WMIN_W'(1);
            if (state_q != ST_WAKEUP)
                wk_cnt <= '0;
            else if (wk_cnt != WK_W'(WK_CYC))
                wk_cnt <= wk_cnt + WK_W'(1);
        end
    end
`else
    logic unused_wakeup;
    assign unused_wakeup = ^{bus.wakeup_req, 32'(WAKE_MIN_US), 32'(WAKE_K_US)};
`endif

    // Next-state selection in priority order: detach, attach, bus reset, per-state exits
    always_comb begin
        state_nxt = state_q;
        if (!bus.pu_ena) begin
            state_nxt = ST_DETACHED;
        end else if (state_q == ST_DETACHED) begin
            state_nxt = ST_ACTIVE;
        end else if (se0_hit) begin
            state_nxt = ST_RESET;
        end else begin
            case (state_q)
                ST_RESET:   if (!line_se0) state_nxt = ST_ACTIVE;
                ST_ACTIVE:  if (idle_hit)  state_nxt = ST_SUSPEND;
                ST_SUSPEND: begin
                    if (k_hit)
                        state_nxt = ST_RESUME;
`ifdef USB_BUS_STATE_WAKEUP_EN
                    else if (wake_go)
                        state_nxt = ST_WAKEUP;
`endif
                end
                ST_RESUME:  if (line_se0)  state_nxt = ST_ACTIVE;
`ifdef USB_BUS_STATE_WAKEUP_EN
                ST_WAKEUP:  if (wk_done)   state_nxt = ST_RESUME;
`endif
                default:    state_nxt = ST_DETACHED;
            endcase
        end
    end

    // Line-condition counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            se0_cnt  <= '0;
            idle_cnt <= '0;
            k_cnt    <= '0;
        end else begin
            if (state_q == ST_DETACHED || !line_se0)
                se0_cnt <= '0;
            else if (se0_cnt != SE0_W'(RESET_CYC))
                se0_cnt <= se0_cnt + SE0_W'(1);
            if (state_q != ST_ACTIVE || !line_j || bus.sof_stb)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_W'(SUSPEND_CYC))
                idle_cnt <= idle_cnt + IDLE_W'(1);
            if (state_q != ST_SUSPEND || !line_k)
                k_cnt <= '0;
            else if (k_cnt != K_W'(RESUME_CYC))
                k_cnt <= k_cnt + K_W'(1);
        end
    end

    // State register with registered status, event and wake-pad outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_DETACHED;
            bus.usb_reset   <= 1'b0;
            bus.usb_suspend <= 1'b0;
            bus.rst_pending <= 1'b1;
            bus.evt_reset   <= 1'b0;
            bus.evt_suspend <= 1'b0;
            bus.evt_resume  <= 1'b0;
            bus.wake_tx_en  <= 1'b0;
            bus.wake_tx_k   <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            bus.usb_reset   <= (state_nxt == ST_RESET);
            bus.usb_suspend <= (state_nxt == ST_SUSPEND) || (state_nxt == ST_WAKEUP);
            bus.rst_pending <= (bus.rst_pending & ~bus.clr_rst_pending) | bus.evt_reset;
            bus.evt_reset   <= (state_nxt == ST_RESET)   && (state_q != ST_RESET);
            bus.evt_suspend <= (state_nxt == ST_SUSPEND) && (state_q != ST_SUSPEND);
            bus.evt_resume  <= (state_nxt == ST_RESUME)  && (state_q != ST_RESUME);
`ifdef USB_BUS_STATE_WAKEUP_EN
            bus.wake_tx_en  <= (state_nxt == ST_WAKEUP);
            bus.wake_tx_k   <= (state_nxt == ST_WAKEUP);
`else
            bus.wake_tx_en  <= 1'b0;
            bus.wake_tx_k   <= 1'b0;
`endif
        end
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_usb_bus_state.sv
// Directed bench for usb_bus_state at CLK_MHZ=4: reset 40, suspend 100, resume 8,
// wake window 20, wake K drive 12 cycles. Expectations follow USB_BUS_STATE_WAKEUP_EN.
module tb_usb_bus_state;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    usb_bus_state_if bus ();

    usb_bus_state #(
        .CLK_MHZ      (4),
        .RESET_US     (10),
        .SUSPEND_US   (25),
        .RESUME_DEB_US(2),
        .WAKE_MIN_US  (5),
        .WAKE_K_US    (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count and report mismatches
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // State plus the three event pulses
    task automatic check_st(input string tag, input int st, input int er, input int es, input int eres);
        check({tag, "_state"},   32'(bus.state),       32'(st));
        check({tag, "_evt_rst"}, 32'(bus.evt_reset),   32'(er));
        check({tag, "_evt_sus"}, 32'(bus.evt_suspend), 32'(es));
        check({tag, "_evt_res"}, 32'(bus.evt_resume),  32'(eres));
    endtask

    // Advance n sample edges; inputs change and outputs are read 1 time unit after the edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic line(input logic dp, input logic dn);
        bus.rx_dp = dp;
        bus.rx_dn = dn;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n               = 1'b0;
        bus.pu_ena          = 1'b1;
        bus.sof_stb         = 1'b0;
        bus.clr_rst_pending = 1'b0;
        bus.wakeup_req      = 1'b0;
        line(1'b1, 1'b0);

        // Power-up
        tick(2);
        check_st("rst", 0, 0, 0, 0);
        check("rst_pending_rst", 32'(bus.rst_pending), 32'd1);
        check("rst_usb_reset",   32'(bus.usb_reset),   32'd0);
        check("rst_usb_susp",    32'(bus.usb_suspend), 32'd0);
        check("rst_wake_en",     32'(bus.wake_tx_en),  32'd0);
        rst_n = 1'b1;
        check("rel_state", 32'(bus.state), 32'd0);
        tick(1);
        check_st("attach", 1, 0, 0, 0);
        check("attach_rst_pending", 32'(bus.rst_pending), 32'd1);

        // Clear the sticky reset flag
        bus.clr_rst_pending = 1'b1;
        tick(1);
        bus.clr_rst_pending = 1'b0;
        check("clr_rst_pending", 32'(bus.rst_pending), 32'd0);

        // SE0 one cycle short of reset
        line(1'b0, 1'b0);
        tick(39);
        check_st("se0_39", 1, 0, 0, 0);
        line(1'b1, 1'b0);
        tick(1);
        check_st("se0_39_j", 1, 0, 0, 0);

        // Full-length SE0 enters RESET
        line(1'b0, 1'b0);
        tick(39);
        check_st("se0_40_pre", 1, 0, 0, 0);
        tick(1);
        check_st("se0_40", 2, 1, 0, 0);
        check("se0_40_usb_reset", 32'(bus.usb_reset), 32'd1);
        check("se0_40_rst_pending", 32'(bus.rst_pending), 32'd0);
        bus.clr_rst_pending = 1'b1;
        tick(1);
        bus.clr_rst_pending = 1'b0;
        check_st("reset_hold", 2, 0, 0, 0);
        check("set_wins_clr", 32'(bus.rst_pending), 32'd1);
        line(1'b1, 1'b0);
        tick(1);
        check_st("reset_exit", 1, 0, 0, 0);
        check("reset_exit_usb_reset", 32'(bus.usb_reset), 32'd0);

        // Idle J into SUSPEND
        tick(99);
        check_st("idle_99", 1, 0, 0, 0);
        tick(1);
        check_st("idle_100", 3, 0, 1, 0);
        check("idle_100_usb_susp", 32'(bus.usb_suspend), 32'd1);

        // Host resume debounce
        line(1'b0, 1'b1);
        tick(7);
        check_st("k_7", 3, 0, 0, 0);
        line(1'b1, 1'b0);
        tick(1);
        line(1'b0, 1'b1);
        tick(7);
        check_st("k_8_pre", 3, 0, 0, 0);
        tick(1);
        check_st("k_8", 4, 0, 0, 1);
        check("k_8_usb_susp", 32'(bus.usb_suspend), 32'd0);

        // End-of-resume SE0 returns to ACTIVE; same SE0 keeps counting toward reset
        line(1'b0, 1'b0);
        tick(1);
        check_st("resume_se0", 1, 0, 0, 0);
        tick(38);
        check_st("resume_se0_39", 1, 0, 0, 0);
        tick(1);
        check_st("resume_se0_40", 2, 1, 0, 0);
        line(1'b1, 1'b0);
        tick(1);
        check_st("resume_reset_exit", 1, 0, 0, 0);

        // SOF every 50 cycles keeps the bus active
        for (int i = 1; i <= 150; i++) begin
            bus.sof_stb = (i % 50 == 0);
            tick(1);
            bus.sof_stb = 1'b0;
        end
        check_st("sof_keepalive", 1, 0, 0, 0);
        tick(100);
        check_st("suspend_again", 3, 0, 1, 0);

        // Remote wakeup: early request ignored, acted on once the window opens
        tick(10);
        bus.wakeup_req = 1'b1;
        tick(10);
        check_st("wake_early", 3, 0, 0, 0);
        check("wake_early_en", 32'(bus.wake_tx_en), 32'd0);
        tick(1);
`ifdef USB_BUS_STATE_WAKEUP_EN
        check_st("wake_enter", 5, 0, 0, 0);
        check("wake_enter_en",   32'(bus.wake_tx_en),  32'd1);
        check("wake_enter_k",    32'(bus.wake_tx_k),   32'd1);
        check("wake_enter_susp", 32'(bus.usb_suspend), 32'd1);
        bus.wakeup_req = 1'b0;
        tick(11);
        check_st("wake_11", 5, 0, 0, 0);
        check("wake_11_en", 32'(bus.wake_tx_en), 32'd1);
        tick(1);
        check_st("wake_done", 4, 0, 0, 1);
        check("wake_done_en", 32'(bus.wake_tx_en), 32'd0);
        check("wake_done_k",  32'(bus.wake_tx_k),  32'd0);
        line(1'b0, 1'b0);
        tick(1);
        check_st("wake_eop", 1, 0, 0, 0);
        line(1'b1, 1'b0);
        tick(100);
        check_st("wake_resuspend", 3, 0, 1, 0);
`else
        check_st("wake_off", 3, 0, 0, 0);
        check("wake_off_en", 32'(bus.wake_tx_en), 32'd0);
        tick(12);
        check_st("wake_off_12", 3, 0, 0, 0);
        check("wake_off_12_en", 32'(bus.wake_tx_en), 32'd0);
        check("wake_off_12_k",  32'(bus.wake_tx_k),  32'd0);
        bus.wakeup_req = 1'b0;
`endif

        // Detach during SUSPEND
        bus.pu_ena = 1'b0;
        tick(1);
        check_st("detach", 0, 0, 0, 0);
        check("detach_usb_susp", 32'(bus.usb_suspend), 32'd0);
        bus.pu_ena = 1'b1;
        tick(1);
        check_st("reattach", 1, 0, 0, 0);
        tick(100);
        check_st("suspend_3", 3, 0, 1, 0);

        // Asynchronous reset mid-operation
        bus.wakeup_req = 1'b1;
        tick(21);
`ifdef USB_BUS_STATE_WAKEUP_EN
        check("pre_rst_state", 32'(bus.state), 32'd5);
        check("pre_rst_en",    32'(bus.wake_tx_en), 32'd1);
`else
        check("pre_rst_state", 32'(bus.state), 32'd3);
`endif
        tick(3);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_state",   32'(bus.state),       32'd0);
        check("async_rst_en",      32'(bus.wake_tx_en),  32'd0);
        check("async_rst_k",       32'(bus.wake_tx_k),   32'd0);
        check("async_rst_susp",    32'(bus.usb_suspend), 32'd0);
        check("async_rst_pending", 32'(bus.rst_pending), 32'd1);
        bus.wakeup_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
